// File: rtl/change_pkg.sv
// ---------------------------------------------------------------------------
// change_pkg : shared states, denomination codes and default coin values
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package change_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SELECT   = 3'd1,
    ST_DISPENSE = 3'd2,
    ST_DONE     = 3'd3,
    ST_SHORT    = 3'd4
  } state_t;

  localparam logic [1:0] C_CODE_D0 = 2'd0;
  localparam logic [1:0] C_CODE_D1 = 2'd1;
  localparam logic [1:0] C_CODE_D2 = 2'd2;
  localparam logic [1:0] C_CODE_D3 = 2'd3;

  localparam int C_D0_DEF = 25;
  localparam int C_D1_DEF = 10;
  localparam int C_D2_DEF = 5;
  localparam int C_D3_DEF = 1;

endpackage

`default_nettype wire

// File: rtl/coin_select.sv
// ---------------------------------------------------------------------------
// coin_select : picks the largest denomination not exceeding the amount owed
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module coin_select
  import change_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] remaining_i,
  input  logic [W-1:0] d0_i,
  input  logic [W-1:0] d1_i,
  input  logic [W-1:0] d2_i,
  input  logic [W-1:0] d3_i,
  output logic [1:0]   code_o,
  output logic [W-1:0] value_o
);

  // Denominations are ordered largest first, so the first fit is the greedy pick.
  always_comb begin
    code_o  = C_CODE_D3;
    value_o = d3_i;
    if (remaining_i >= d0_i) begin
      code_o  = C_CODE_D0;
      value_o = d0_i;
    end else if (remaining_i >= d1_i) begin
      code_o  = C_CODE_D1;
      value_o = d1_i;
    end else if (remaining_i >= d2_i) begin
      code_o  = C_CODE_D2;
      value_o = d2_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/change_dispenser.sv
// ---------------------------------------------------------------------------
// change_dispenser : computes Paid-Total and pays it out one coin per handshake
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module change_dispenser
  import change_pkg::*;
#(
  parameter int W  = 8,
  parameter int D0 = C_D0_DEF,
  parameter int D1 = C_D1_DEF,
  parameter int D2 = C_D2_DEF,
  parameter int D3 = C_D3_DEF
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         Start,
  input  logic [W-1:0] Total,
  input  logic [W-1:0] Paid,
  input  logic         CoinAck,
  output logic         CoinValid,
  output logic [1:0]   CoinDenom,
  output logic [W-1:0] Remaining,
  output logic [W-1:0] CoinCount,
  output logic         Busy,
  output logic         Done,
  output logic         Short
);

  localparam logic [W-1:0] C_D0  = W'(D0);
  localparam logic [W-1:0] C_D1  = W'(D1);
  localparam logic [W-1:0] C_D2  = W'(D2);
  localparam logic [W-1:0] C_D3  = W'(D3);
  localparam logic [W-1:0] C_ONE = W'(1);

  state_t         state_q, state_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic           valid_q, valid_d;
  logic [1:0]     denom_q, denom_d;

  logic [1:0]     sel_code;
  logic [W-1:0]   sel_value;
  logic [W-1:0]   denom_value;

  coin_select #(.W(W)) u_coin_select (
    .remaining_i (rem_q),
    .d0_i        (C_D0),
    .d1_i        (C_D1),
    .d2_i        (C_D2),
    .d3_i        (C_D3),
    .code_o      (sel_code),
    .value_o     (sel_value)
  );

  // The amount deducted on ack follows the latched code, not the live selector.
  always_comb begin
    case (denom_q)
      C_CODE_D0: denom_value = C_D0;
      C_CODE_D1: denom_value = C_D1;
      C_CODE_D2: denom_value = C_D2;
      default:   denom_value = C_D3;
    endcase
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    denom_d = denom_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          cnt_d = '0;
          if (Paid >= Total) begin
            rem_d   = Paid - Total;
            state_d = ST_SELECT;
          end else begin
            rem_d   = '0;
            state_d = ST_SHORT;
          end
        end
      end
      ST_SELECT: begin
        if (rem_q == '0) begin
          state_d = ST_DONE;
        end else begin
          denom_d = sel_code;
          valid_d = 1'b1;
          state_d = ST_DISPENSE;
        end
      end
      ST_DISPENSE: begin
        if (CoinAck) begin
          rem_d   = rem_q - denom_value;
          cnt_d   = cnt_q + C_ONE;
          valid_d = 1'b0;
          state_d = ST_SELECT;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_SHORT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      denom_q <= 2'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      denom_q <= denom_d;
    end
  end

  assign CoinValid = valid_q;
  assign CoinDenom = denom_q;
  assign Remaining = rem_q;
  assign CoinCount = cnt_q;
  assign Busy      = (state_q != ST_IDLE);
  assign Done      = (state_q == ST_DONE);
  assign Short     = (state_q == ST_SHORT);

  logic unused_sel_value;
  assign unused_sel_value = ^sel_value;

endmodule

`default_nettype wire

// File: tb/tb_change_dispenser.sv
// ---------------------------------------------------------------------------
// tb_change_dispenser : directed payouts checked through a scoreboard queue
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_change_dispenser;

  localparam int K_COIN  = 0;
  localparam int K_DONE  = 1;
  localparam int K_SHORT = 2;

  typedef struct {
    int kind;
    int code;
    int val;
  } exp_t;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Start;
  logic [7:0] Total;
  logic [7:0] Paid;
  logic       CoinAck;
  logic       CoinValid;
  logic [1:0] CoinDenom;
  logic [7:0] Remaining;
  logic [7:0] CoinCount;
  logic       Busy;
  logic       Done;
  logic       Short;

  int   checks    = 0;
  int   fails     = 0;
  int   ack_delay = 0;
  exp_t sb[$];

  change_dispenser #(.W(8)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Start     (Start),
    .Total     (Total),
    .Paid      (Paid),
    .CoinAck   (CoinAck),
    .CoinValid (CoinValid),
    .CoinDenom (CoinDenom),
    .Remaining (Remaining),
    .CoinCount (CoinCount),
    .Busy      (Busy),
    .Done      (Done),
    .Short     (Short)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int kind, input int code, input int val);
    exp_t e;
    e.kind = kind;
    e.code = code;
    e.val  = val;
    sb.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge following the Start edge.
  task automatic start_payout(input int t, input int p);
    Total = 8'(t);
    Paid  = 8'(p);
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    for (n = 0; n < 500; n++) begin
      if (!Busy) break;
      @(negedge Clock);
    end
    chk({name, "_idle_timeout"}, 32'(n >= 500), 0);
  endtask

  task automatic wait_coin_count(input int c);
    int n;
    for (n = 0; n < 200; n++) begin
      @(negedge Clock);
      if (CoinValid && CoinCount == 8'(c)) break;
    end
    chk("wait_valid_timeout", 32'(n >= 200), 0);
  endtask

  // Hopper model: acks immediately, or after ack_delay cycles of CoinValid.
  initial begin : ack_drv
    int cnt;
    cnt     = 0;
    CoinAck = 1'b0;
    forever begin
      @(posedge Clock);
      #2;
      if (ack_delay == 0) begin
        CoinAck = 1'b1;
      end else if (CoinValid) begin
        cnt++;
        CoinAck = (cnt >= ack_delay);
      end else begin
        cnt     = 0;
        CoinAck = 1'b0;
      end
    end
  end

  initial begin : monitor
    logic       prev_valid, prev_acc, prev_done, prev_short;
    logic [1:0] prev_denom;
    logic [7:0] prev_rem;
    exp_t       e;
    prev_valid = 1'b0;
    prev_acc   = 1'b0;
    prev_done  = 1'b0;
    prev_short = 1'b0;
    prev_denom = 2'd0;
    prev_rem   = 8'd0;
    forever begin
      @(negedge Clock);
      if (CoinValid === 1'b1 && prev_valid && !prev_acc) begin
        chk("denom_stable", 32'(CoinDenom), 32'(prev_denom));
        chk("rem_stable", 32'(Remaining), 32'(prev_rem));
      end
      if (CoinValid === 1'b1 && CoinAck === 1'b1) begin
        if (sb.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_coin: got code %0d, expected none", CoinDenom);
        end else begin
          e = sb.pop_front();
          chk("coin_kind", 32'(K_COIN), 32'(e.kind));
          chk("coin_code", 32'(CoinDenom), 32'(e.code));
          chk("coin_rem", 32'(Remaining), 32'(e.val));
        end
      end
      if (Done === 1'b1) begin
        chk("done_pulse_width", 32'(prev_done), 0);
        if (sb.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_done: got Done=1, expected 0");
        end else begin
          e = sb.pop_front();
          chk("done_kind", K_DONE, 32'(e.kind));
          chk("done_count", 32'(CoinCount), 32'(e.val));
          chk("done_rem", 32'(Remaining), 0);
        end
      end
      if (Short === 1'b1) begin
        chk("short_pulse_width", 32'(prev_short), 0);
        if (sb.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_short: got Short=1, expected 0");
        end else begin
          e = sb.pop_front();
          chk("short_kind", K_SHORT, 32'(e.kind));
          chk("short_count", 32'(CoinCount), 0);
          chk("short_rem", 32'(Remaining), 0);
        end
      end
      prev_valid = (CoinValid === 1'b1);
      prev_acc   = (CoinValid === 1'b1) && (CoinAck === 1'b1);
      prev_done  = (Done === 1'b1);
      prev_short = (Short === 1'b1);
      prev_denom = CoinDenom;
      prev_rem   = Remaining;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    Reset = 1'b1;
    Start = 1'b1;
    Total = 8'd0;
    Paid  = 8'd9;
    repeat (2) @(negedge Clock);
    chk("rst_valid", 32'(CoinValid), 0);
    chk("rst_denom", 32'(CoinDenom), 0);
    chk("rst_rem", 32'(Remaining), 0);
    chk("rst_count", 32'(CoinCount), 0);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_done", 32'(Done), 0);
    chk("rst_short", 32'(Short), 0);
    Start = 1'b0;
    Reset = 1'b0;
    @(negedge Clock);

    // 100-37 = 63 -> 25,25,10,1,1,1 with hopper acking at once
    ack_delay = 0;
    push(K_COIN, 0, 63); push(K_COIN, 0, 38); push(K_COIN, 1, 13);
    push(K_COIN, 3, 3);  push(K_COIN, 3, 2);  push(K_COIN, 3, 1);
    push(K_DONE, 0, 6);
    start_payout(37, 100);
    chk("p1_busy", 32'(Busy), 1);
    chk("p1_valid_early", 32'(CoinValid), 0);
    @(negedge Clock);
    chk("p1_valid_latency", 32'(CoinValid), 1);
    chk("p1_first_denom", 32'(CoinDenom), 0);
    wait_idle("p1");
    chk("p1_count", 32'(CoinCount), 6);
    chk("p1_rem", 32'(Remaining), 0);
    @(negedge Clock);

    // exact payment: Done two cycles after Start
    push(K_DONE, 0, 0);
    start_payout(50, 50);
    chk("p2_done_early", 32'(Done), 0);
    @(negedge Clock);
    chk("p2_done_latency", 32'(Done), 1);
    chk("p2_no_valid", 32'(CoinValid), 0);
    wait_idle("p2");
    chk("p2_count", 32'(CoinCount), 0);
    @(negedge Clock);

    // underpayment
    push(K_SHORT, 0, 0);
    start_payout(80, 60);
    chk("p3_short", 32'(Short), 1);
    chk("p3_no_valid", 32'(CoinValid), 0);
    @(negedge Clock);
    chk("p3_busy_low", 32'(Busy), 0);
    chk("p3_short_low", 32'(Short), 0);
    @(negedge Clock);

    // 255 with slow hopper -> 10x25 then 5
    ack_delay = 3;
    for (int i = 0; i < 10; i++) push(K_COIN, 0, 255 - 25 * i);
    push(K_COIN, 2, 5);
    push(K_DONE, 0, 11);
    start_payout(0, 255);
    wait_idle("p4");
    chk("p4_count", 32'(CoinCount), 11);
    chk("p4_rem", 32'(Remaining), 0);
    @(negedge Clock);

    // reset during the second coin of a 30 payout
    push(K_COIN, 0, 30);
    start_payout(0, 30);
    wait_coin_count(1);
    Reset = 1'b1;
    @(negedge Clock);
    chk("p5_rst_valid", 32'(CoinValid), 0);
    chk("p5_rst_rem", 32'(Remaining), 0);
    chk("p5_rst_count", 32'(CoinCount), 0);
    chk("p5_rst_busy", 32'(Busy), 0);
    chk("p5_rst_done", 32'(Done), 0);
    Reset = 1'b0;
    @(negedge Clock);
    push(K_COIN, 2, 6); push(K_COIN, 3, 1); push(K_DONE, 0, 2);
    start_payout(4, 10);
    wait_idle("p5b");
    chk("p5b_count", 32'(CoinCount), 2);
    @(negedge Clock);

    // Start with new operands while dispensing is ignored
    push(K_COIN, 1, 16); push(K_COIN, 2, 6); push(K_COIN, 3, 1); push(K_DONE, 0, 3);
    start_payout(0, 16);
    wait_coin_count(0);
    Total = 8'd0;
    Paid  = 8'd99;
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    wait_idle("p6");
    chk("p6_count", 32'(CoinCount), 3);
    chk("p6_rem", 32'(Remaining), 0);
    repeat (3) @(negedge Clock);
    chk("p6_still_idle", 32'(Busy), 0);

    chk("sb_drained", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
